// File: rtl/fpga_ccff_loader.sv
// fpga_ccff_loader: byte stream to configuration chain serialiser, MSB first.
// Define CCFF_LOADER_VERIFY_EN to add a recirculating CRC-8 readback check.
module fpga_ccff_loader #(
  parameter int CHAIN_LEN = 96,
  parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic             prog_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, VERIFY, DONE} state_t;
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
`ifdef CCFF_LOADER_VERIFY_EN
  localparam state_t AFTER_LOAD = VERIFY;
`else
  localparam state_t AFTER_LOAD = DONE;
`endif
  state_t state, state_nx;
  logic [7:0] shreg;
  logic [3:0] nleft;
  logic [3:0] nbits;
  logic [CNT_W+3:0] remain;
  logic verify_last;
  // The last byte may carry fewer useful bits than eight
  assign remain = (CNT_W + 4)'(LEN) - (CNT_W + 4)'(bit_count);
  assign nbits = remain > (CNT_W + 4)'(8) ? 4'd8 : remain[3:0];
  always_ff @(posedge prog_clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? FETCH : IDLE;
      FETCH:   state_nx = s_valid ? SHIFT : FETCH;
      SHIFT:   state_nx = nleft != 4'd1 ? SHIFT : bit_count == LEN_M1 ? AFTER_LOAD : FETCH;
      VERIFY:  state_nx = verify_last ? DONE : VERIFY;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    s_ready = state == FETCH;
    ccff_shift_en = state == SHIFT || state == VERIFY;
    busy = state != IDLE;
    done = state == DONE;
    ccff_head = state == SHIFT ? shreg[7] : state == VERIFY ? ccff_tail : 1'b0;
  end
  always_ff @(posedge prog_clk)
    if (!reset) begin
      shreg <= '0;
      nleft <= '0;
      bit_count <= '0;
    end else if (state == IDLE && start) begin
      bit_count <= '0;
    end else if (state == FETCH && s_valid) begin
      shreg <= s_data;
      nleft <= nbits;
    end else if (state == SHIFT) begin
      shreg <= {shreg[6:0], 1'b0};
      nleft <= nleft - 4'd1;
      bit_count <= bit_count + ONE;
    end
`ifdef CCFF_LOADER_VERIFY_EN
  logic [7:0] crc_tx, crc_rx, crc_rx_nx;
  logic [CNT_W-1:0] vcnt;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
  assign crc_rx_nx = crc8(crc_rx, ccff_tail);
  assign verify_last = vcnt == LEN_M1;
  // Recirculating the tail restores the chain while it is read back
  always_ff @(posedge prog_clk)
    if (!reset || (state == IDLE && start)) begin
      crc_tx <= '0;
      crc_rx <= '0;
      vcnt <= '0;
      error <= 1'b0;
    end else if (state == SHIFT) begin
      crc_tx <= crc8(crc_tx, shreg[7]);
    end else if (state == VERIFY) begin
      crc_rx <= crc_rx_nx;
      vcnt <= vcnt + ONE;
      if (verify_last) error <= crc_rx_nx != crc_tx;
    end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign verify_last = 1'b0;
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_fpga_ccff_loader.sv
// tb_fpga_ccff_loader: table-driven loads with a bit scoreboard and a behavioural chain model.
module tb_fpga_ccff_loader;
  localparam int L = 12;
  localparam int CW = $clog2(L + 1);
`ifdef CCFF_LOADER_VERIFY_EN
  localparam int VF = 1;
`else
  localparam int VF = 0;
`endif
  logic prog_clk = 0, reset = 0, start = 0, s_valid = 0;
  logic [7:0] s_data = '0;
  logic s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
  logic [CW-1:0] bit_count;
  always #5 prog_clk = ~prog_clk;

  fpga_ccff_loader #(.CHAIN_LEN(L)) dut (
    .prog_clk(prog_clk), .reset(reset), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy),
    .done(done), .error(error), .bit_count(bit_count)
  );

  int checks = 0, errors = 0, cyc = 0, c0 = 0, shifts = 0, dones = 0, done_t = -1;
  int pushed = 0, flip_at = -1;
  bit exp_q[$];
  logic [L-1:0] got = '0;
  logic [L-1:0] chain = '0;

  assign ccff_tail = chain[L-1];
  always @(posedge prog_clk) begin
    cyc++;
    if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head ^ (shifts == flip_at)};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge prog_clk) begin
    if (ccff_shift_en) begin
      if (exp_q.size() > 0) begin
        chk("head", ccff_head, exp_q.pop_front());
        got = {got[L-2:0], ccff_head};
      end else begin
`ifdef CCFF_LOADER_VERIFY_EN
        chk("verify_head", ccff_head, ccff_tail);
`else
        checks++;
        errors++;
        $display("FAIL extra_shift: got shift_en=1 expected 0 at cycle %0d", cyc - c0);
`endif
      end
      shifts++;
    end
    if (done) begin
      dones++;
      done_t = cyc - c0;
    end
  end

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int gap;
    logic [L-1:0] bits;
    int done_t;
  } vec_t;
  vec_t vt[5];

  task automatic do_start();
    start = 1;
    c0 = cyc;
    shifts = 0;
    dones = 0;
    done_t = -1;
    got = '0;
    pushed = 0;
    @(negedge prog_clk);
    start = 0;
    chk("fetch_ready", s_ready, 1);
    chk("fetch_busy", busy, 1);
    chk("start_clr_count", bit_count, 0);
    chk("start_clr_error", error, 0);
  endtask

  task automatic feed(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      s_valid = 0;
      while (!s_ready && n < 50) begin @(negedge prog_clk); n++; end
      repeat (gap) begin
        chk("stall_ready", s_ready, 1);
        chk("stall_shift", ccff_shift_en, 0);
        @(negedge prog_clk);
      end
    end
    s_data = b;
    s_valid = 1;
    n = 0;
    while (!s_ready && n < 50) begin @(negedge prog_clk); n++; end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got s_ready=0 expected 1");
    end
    for (int i = 7; i >= 0 && pushed < L; i--) begin
      exp_q.push_back(b[i]);
      pushed++;
    end
    @(negedge prog_clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (dones == 0 && n < 200) begin @(negedge prog_clk); n++; end
    s_valid = 0;
    repeat (3) @(negedge prog_clk);
    chk("done_count", dones, 1);
    chk("shift_count", shifts, L * (1 + VF));
    chk("final_count", bit_count, L);
    chk("idle_busy", busy, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    do_start();
    feed(v.b0, 0);
    feed(v.b1, v.gap);
    wait_done();
    chk("bits", got, v.bits);
    chk("done_time", done_t, v.done_t + VF * L);
    chk("no_error", error, 0);
  endtask

  initial begin
    vt[0] = '{8'hA5, 8'h3C, 0, 12'hA53, 15};
    vt[1] = '{8'hFF, 8'hB7, 0, 12'hFFB, 15};
    vt[2] = '{8'h00, 8'h0F, 0, 12'h000, 15};
    vt[3] = '{8'h81, 8'h40, 5, 12'h814, 20};
    vt[4] = '{8'h5A, 8'hE9, 2, 12'h5AE, 17};
    repeat (3) @(negedge prog_clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift", ccff_shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_count", bit_count, 0);
    reset = 1;
    @(negedge prog_clk);
    for (int k = 0; k < 5; k++) run_vec(vt[k]);
    // start while busy must not restart or add a done
    do_start();
    feed(8'hC3, 0);
    repeat (3) @(negedge prog_clk);
    start = 1;
    @(negedge prog_clk);
    start = 0;
    feed(8'h96, 0);
    wait_done();
    chk("busy_start_bits", got, 12'hC39);
    // reset in the middle of a byte
    do_start();
    feed(8'hF0, 0);
    repeat (4) @(negedge prog_clk);
    reset = 0;
    @(negedge prog_clk);
    chk("abort_busy", busy, 0);
    chk("abort_shift", ccff_shift_en, 0);
    chk("abort_ready", s_ready, 0);
    chk("abort_count", bit_count, 0);
    reset = 1;
    exp_q.delete();
    repeat (4) @(negedge prog_clk);
    chk("abort_no_done", dones, 0);
    run_vec(vt[1]);
`ifdef CCFF_LOADER_VERIFY_EN
    flip_at = 3;
    do_start();
    feed(8'h6D, 0);
    feed(8'h20, 0);
    wait_done();
    chk("verify_error", error, 1);
    flip_at = -1;
    run_vec(vt[0]);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/fpga_ccff_loader.md
# fpga_ccff_loader

Configuration-chain loader for the FPGA fabric. It accepts a bitstream as a byte stream over a valid/ready handshake and serialises it, MSB first, into the fabric's configuration flip-flop chain (`ccff_head`), issuing exactly CHAIN_LEN shift enables per load. It sits beside `fpga_top` in the `prog_clk` domain and drives the chain head, the shift-enable used to gate `prog_clk` into the chain, and observes `ccff_tail`.

## Interface
- CHAIN_LEN, 96: number of configuration flip-flops in the chain (≥1).
- CNT_W, $clog2(CHAIN_LEN+1): derived; width of bit counter.

- prog_clk  in  1  programming clock; sole clock of the block.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on prog_clk rising edge).
- start  in  1  begin a load; honoured only in IDLE.
- s_data  in  8  bitstream byte; bit 7 shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block accepts s_data this cycle.
- ccff_head  out  1  serial data into chain.
- ccff_shift_en  out  1  chain captures ccff_head on this prog_clk edge.
- ccff_tail  in  1  serial data out of chain.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of load.
- error  out  1  verify mismatch, sticky until next accepted start (see Configuration).
- bit_count  out  CNT_W  bits shifted into chain so far in current load.

## Operation
- States: IDLE, FETCH, SHIFT, VERIFY (macro only), DONE.
- IDLE: outputs quiescent. start=1 → FETCH; clears bit_count, error, CRC registers.
- FETCH: s_ready=1. On s_valid&&s_ready, byte loaded into 8-bit shift register, nbits = min(8, CHAIN_LEN−bit_count); → SHIFT. No valid → stay (stall indefinitely).
- SHIFT: each cycle ccff_shift_en=1, ccff_head=shreg[7], shreg<<=1, bit_count+=1. After nbits cycles: bit_count==CHAIN_LEN → VERIFY (macro) or DONE; else → FETCH.
- Partial final byte: when CHAIN_LEN%8≠0, only upper CHAIN_LEN%8 bits of last byte shifted; lower bits discarded.
- DONE: done=1 for one cycle; → IDLE.
- start outside IDLE ignored. s_valid outside FETCH ignored (s_ready=0).
- Reset during any state: next edge returns to IDLE, all outputs to reset values; chain contents undefined; no done.

## Timing
- Reset values: s_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0, bit_count=0.
- All outputs registered except ccff_head in VERIFY (combinational from ccff_tail).
- start at cycle 0 → FETCH at cycle 1. Handshake in cycle t → first shift in t+1.
- Per byte with s_valid held high: 1 FETCH + 8 SHIFT cycles.
- CHAIN_LEN=16, s_valid always 1, start at cycle 0: shifts cycles 2–9 and 11–18; done in cycle 19 (no verify).
- ccff_shift_en high in exactly CHAIN_LEN cycles per load (2·CHAIN_LEN with verify).
- bit_count updates the cycle after each shift; holds final value through DONE and IDLE until next start.

## Configuration
- Macro CCFF_LOADER_VERIFY_EN.
- Defined: CRC-8 (poly 0x07, init 0x00, MSB-first) accumulated over every bit driven into ccff_head in SHIFT. After final shift → VERIFY for CHAIN_LEN cycles: ccff_shift_en=1, ccff_head=ccff_tail (recirculation restores chain contents), second CRC-8 accumulated over ccff_tail. At VERIFY end, CRCs differ → error=1. Then DONE (done still pulses). bit_count unchanged in VERIFY.
- Undefined: no VERIFY state, no CRC logic, error tied 0.

## Test plan
- Reset then CHAIN_LEN=16, bytes 0xA5,0x3C, s_valid always 1 → ccff_head sequence 1010_0101_0011_1100 on shift cycles 2–9, 11–18; done at cycle 19; bit_count=16.
- CHAIN_LEN=12, bytes 0xFF,0xB7 → 12 shifts, last four bits 1011; 0x7 nibble dropped; done once.
- s_valid deasserted 5 cycles in FETCH → s_ready held, no ccff_shift_en, load resumes with no lost/duplicated bits.
- reset=0 mid-SHIFT at bit 5 → next cycle IDLE, ccff_shift_en=0, busy=0, no done; subsequent start completes normally.
- start pulsed while busy → ignored; exactly one done, CHAIN_LEN shifts.
- VERIFY_EN, behavioural chain model loopback → error=0; inject single flipped bit in chain model → error=1 after done, cleared by next start.
